// File: rtl/serial_jk_excitation_driver_pkg.sv
// Shared definitions for the serial JK excitation driver.
//   state_t    : controller states (IDLE, DRIVE, RELEASE, CHECK)
//   cnt_width  : counter width helper for the hold and retry counters
package serial_jk_excitation_driver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2,
    CHECK   = 2'd3
  } state_t;

  // Bits needed to hold values 0..max_val; never narrower than one bit so a
  // zero-valued limit (single attempt, or HOLD=1) still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/serial_jk_excitation_driver_jk_excite.sv
// Per-bit J/K excitation for driving a JK latch bank toward a wanted word.
//   expected : word the bank should hold
//   q        : current Q outputs of the bank
//   j        : set excitation   (bit wanted 1, currently 0)
//   k        : reset excitation (bit wanted 0, currently 1)
// Bits that are already correct get J=K=0, and J=K=1 can never be produced,
// so the latches are never asked to toggle.
module jk_excite #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] expected,
  input  logic [SIZE-1:0] q,
  output logic [SIZE-1:0] j,
  output logic [SIZE-1:0] k
);

  assign j = expected & ~q;
  assign k = ~expected & q;

endmodule

// File: rtl/serial_jk_excitation_driver.sv
// Write-side controller for a SIZE-bit JK latch bank.
// A request (target word, or toggle mask when mode=1) is accepted over a
// valid/ready handshake, turned into J/K excitation held for HOLD cycles,
// released for one settle cycle and then verified against Q_fb. Mismatches
// are retried up to MAX_RETRY times; completion gives a one-cycle done pulse
// and a sticky err flag with the final mismatch bits.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   mode, target        : 0 = write target, 1 = toggle bits set in target
//   Q_fb                : Q outputs of the driven bank
//   J, K                : registered set/reset excitation
//   done, err, mismatch : completion pulse, sticky failure, failing bits
module serial_jk_excitation_driver
  import serial_jk_excitation_driver_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int HOLD      = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            mode,
  input  logic [SIZE-1:0] target,
  input  logic [SIZE-1:0] Q_fb,
  output logic [SIZE-1:0] J,
  output logic [SIZE-1:0] K,
  output logic            done,
  output logic            err,
  output logic [SIZE-1:0] mismatch
);

  localparam int HOLD_W  = cnt_width(HOLD - 1);
  localparam int RETRY_W = cnt_width(MAX_RETRY);

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [SIZE-1:0]   expected;
  logic [SIZE-1:0]   expected_nxt;
  logic [SIZE-1:0]   j_nxt;
  logic [SIZE-1:0]   k_nxt;
  logic              done_nxt;
  logic              err_nxt;
  logic [SIZE-1:0]   mismatch_nxt;
  logic [SIZE-1:0]   accept_exp;
  logic [SIZE-1:0]   exc_exp;
  logic [SIZE-1:0]   exc_j;
  logic [SIZE-1:0]   exc_k;

  // Word the request asks for, evaluated against Q_fb at the accept edge.
  assign accept_exp = mode ? (Q_fb ^ target) : target;

  // Excitation source: a fresh request while idle, otherwise the latched
  // expected word (used when a retry re-enters DRIVE from CHECK).
  assign exc_exp = (state == IDLE) ? accept_exp : expected;

  jk_excite #(
    .SIZE(SIZE)
  ) u_excite (
    .expected(exc_exp),
    .q       (Q_fb),
    .j       (exc_j),
    .k       (exc_k)
  );

  // Next-state and next-output logic for the drive/release/check sequence.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    retry_nxt    = retry_cnt;
    expected_nxt = expected;
    j_nxt        = '0;
    k_nxt        = '0;
    done_nxt     = 1'b0;
    err_nxt      = err;
    mismatch_nxt = mismatch;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          expected_nxt = accept_exp;
          err_nxt      = 1'b0;
          mismatch_nxt = '0;
          retry_nxt    = '0;
          hold_nxt     = '0;
          j_nxt        = exc_j;
          k_nxt        = exc_k;
          state_nxt    = DRIVE;
        end else begin
          state_nxt = IDLE;
        end
      end
      DRIVE: begin
        if (hold_cnt == HOLD_W'(HOLD - 1)) begin
          state_nxt = RELEASE;
        end else begin
          // Keep the excitation that was registered on entry to DRIVE.
          hold_nxt = hold_cnt + HOLD_W'(1);
          j_nxt    = J;
          k_nxt    = K;
        end
      end
      RELEASE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        if (Q_fb == expected) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
          // Recompute from the present Q so only still-wrong bits are driven.
          retry_nxt = retry_cnt + RETRY_W'(1);
          hold_nxt  = '0;
          j_nxt     = exc_j;
          k_nxt     = exc_k;
          state_nxt = DRIVE;
        end else begin
          state_nxt    = IDLE;
          done_nxt     = 1'b1;
          err_nxt      = 1'b1;
          mismatch_nxt = Q_fb ^ expected;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      retry_cnt <= '0;
      expected  <= '0;
      J         <= '0;
      K         <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      mismatch  <= '0;
      req_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      retry_cnt <= retry_nxt;
      expected  <= expected_nxt;
      J         <= j_nxt;
      K         <= k_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      mismatch  <= mismatch_nxt;
      req_ready <= (state_nxt == IDLE);
    end
  end

endmodule

// File: tb/tb_serial_jk_excitation_driver.sv
// Self-checking bench: a behavioural JK latch bank (with an optional stuck-at-0
// bit 3) feeds Q_fb back to the driver; each scenario predicts the outcome
// from the request alone (expected word, pass/fail, latency).
module tb_serial_jk_excitation_driver;

  localparam int SIZE   = 8;
  localparam int HOLD_T = 1;
  localparam int MAX_R  = 3;
  localparam int BUDGET = 200;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            mode;
  logic [SIZE-1:0] target;
  logic [SIZE-1:0] Q_fb;
  logic [SIZE-1:0] J;
  logic [SIZE-1:0] K;
  logic            done;
  logic            err;
  logic [SIZE-1:0] mismatch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_jk_excitation_driver #(
    .SIZE(SIZE), .HOLD(HOLD_T), .MAX_RETRY(MAX_R)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mode(mode), .target(target), .Q_fb(Q_fb), .J(J), .K(K),
    .done(done), .err(err), .mismatch(mismatch)
  );

  // Latch bank model: J sets, K clears, bit 3 reads 0 while stuck is on.
  logic [SIZE-1:0] q_mem;
  logic            stuck;
  logic            load_en;
  logic [SIZE-1:0] load_val;
  assign Q_fb = stuck ? (q_mem & 8'hF7) : q_mem;

  always @(posedge clk) begin
    if (load_en) q_mem <= load_val;
    else         q_mem <= (q_mem | (J & ~K)) & ~(K & ~J);
  end

  // Accept counter and per-cycle protocol monitor.
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (req_valid === 1'b1 && req_ready === 1'b1 && reset === 1'b0) acc_cnt <= acc_cnt + 1;
  end

  int   mon_bad = 0;
  int   acc_prev = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if ((J & K) !== 8'h00) begin
      mon_bad = mon_bad + 1;
      $display("FAIL jk_exclusive: J=%h K=%h J&K=%h required 00", J, K, J & K);
    end
    if (done === 1'b1 && prev_done === 1'b1 && acc_cnt == acc_prev) begin
      mon_bad = mon_bad + 1;
      $display("FAIL done_repeat: done high in consecutive cycles without an accept");
    end
    prev_done = done;
    acc_prev  = acc_cnt;
  end

  task automatic load_q(input logic [SIZE-1:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(posedge clk);
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issues one request (called just after a negedge) and observes it up to done.
  task automatic do_request(input logic m, input logic [SIZE-1:0] tgt, input logic stk,
                            output logic [SIZE-1:0] exp_w, output int lat, output int phases,
                            output logic [SIZE-1:0] first_j, output logic [SIZE-1:0] first_k,
                            output logic [SIZE-1:0] last_j, output logic [SIZE-1:0] last_k,
                            output logic err_o, output logic [SIZE-1:0] mis_o,
                            output logic [SIZE-1:0] q_o);
    logic [SIZE-1:0] qv;
    logic prev_nz;
    logic nz;
    stuck     = stk;
    qv        = stk ? (q_mem & 8'hF7) : q_mem;
    exp_w     = m ? (qv ^ tgt) : tgt;
    req_valid = 1'b1;
    mode      = m;
    target    = tgt;
    @(posedge clk);
    lat = 0; phases = 0; prev_nz = 1'b0;
    first_j = '0; first_k = '0; last_j = '0; last_k = '0;
    while (lat < BUDGET) begin
      @(negedge clk);
      lat = lat + 1;
      req_valid = 1'b0;
      if (lat == 1) begin
        first_j = J;
        first_k = K;
      end
      nz = ((J | K) != 8'h00);
      if (nz && !prev_nz) phases = phases + 1;
      if (nz) begin
        last_j = J;
        last_k = K;
      end
      prev_nz = nz;
      if (done === 1'b1) break;
    end
    err_o = err;
    mis_o = mismatch;
    q_o   = Q_fb;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; mode = 1'b0; target = '0;
    stuck = 1'b0; load_en = 1'b1; load_val = 8'h0F;
    repeat (3) @(negedge clk);
    total = total + 6;
    if (J !== 8'h00)        begin bad++; $display("FAIL reset_J: got %h want 00", J); end
    if (K !== 8'h00)        begin bad++; $display("FAIL reset_K: got %h want 00", K); end
    if (done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    if (err !== 1'b0)       begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    if (mismatch !== 8'h00) begin bad++; $display("FAIL reset_mismatch: got %h want 00", mismatch); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    reset = 1'b0; load_en = 1'b0;
  endtask

  task automatic test_write();
    logic [SIZE-1:0] ew, fj, fk, lj, lk, mo, qo; int lat, ph; logic eo;
    load_q(8'h0F);
    do_request(1'b0, 8'hF0, 1'b0, ew, lat, ph, fj, fk, lj, lk, eo, mo, qo);
    total = total + 6;
    if (fj !== 8'hF0)     begin bad++; $display("FAIL write_J: got %h want F0", fj); end
    if (fk !== 8'h0F)     begin bad++; $display("FAIL write_K: got %h want 0F", fk); end
    if (ph != 1)          begin bad++; $display("FAIL write_phases: got %0d want 1", ph); end
    if (lat != HOLD_T + 3) begin bad++; $display("FAIL write_latency: got %0d want %0d", lat, HOLD_T + 3); end
    if (eo !== 1'b0)      begin bad++; $display("FAIL write_err: got %b want 0", eo); end
    if (qo !== 8'hF0)     begin bad++; $display("FAIL write_q: got %h want F0", qo); end
  endtask

  task automatic test_toggle();
    logic [SIZE-1:0] ew, fj, fk, lj, lk, mo, qo; int lat, ph; logic eo;
    load_q(8'h0F);
    do_request(1'b1, 8'h81, 1'b0, ew, lat, ph, fj, fk, lj, lk, eo, mo, qo);
    total = total + 5;
    if (fj !== 8'h80)     begin bad++; $display("FAIL toggle_J: got %h want 80", fj); end
    if (fk !== 8'h01)     begin bad++; $display("FAIL toggle_K: got %h want 01", fk); end
    if (lat != HOLD_T + 3) begin bad++; $display("FAIL toggle_latency: got %0d want %0d", lat, HOLD_T + 3); end
    if (eo !== 1'b0)      begin bad++; $display("FAIL toggle_err: got %b want 0", eo); end
    if (qo !== 8'h8E)     begin bad++; $display("FAIL toggle_q: got %h want 8E", qo); end
  endtask

  task automatic test_stuck();
    logic [SIZE-1:0] ew, fj, fk, lj, lk, mo, qo; int lat, ph, want_lat; logic eo;
    load_q(8'h00);
    do_request(1'b0, 8'hFF, 1'b1, ew, lat, ph, fj, fk, lj, lk, eo, mo, qo);
    want_lat = (MAX_R + 1) * (HOLD_T + 2) + 1;
    total = total + 7;
    if (fj !== 8'hFF)      begin bad++; $display("FAIL stuck_first_J: got %h want FF", fj); end
    if (ph != MAX_R + 1)   begin bad++; $display("FAIL stuck_phases: got %0d want %0d", ph, MAX_R + 1); end
    if (lj !== 8'h08)      begin bad++; $display("FAIL stuck_retry_J: got %h want 08", lj); end
    if (lk !== 8'h00)      begin bad++; $display("FAIL stuck_retry_K: got %h want 00", lk); end
    if (lat != want_lat)   begin bad++; $display("FAIL stuck_latency: got %0d want %0d", lat, want_lat); end
    if (eo !== 1'b1)       begin bad++; $display("FAIL stuck_err: got %b want 1", eo); end
    if (mo !== 8'h08)      begin bad++; $display("FAIL stuck_mismatch: got %h want 08", mo); end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [SIZE-1:0] ew, fj, fk, lj, lk, mo, qo; int lat, ph; logic eo;
    load_q(8'h00);
    req_valid = 1'b1; mode = 1'b0; target = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total = total + 1;
    if (J !== 8'h3C) begin bad++; $display("FAIL midreset_drive_J: got %h want 3C", J); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total = total + 5;
    if (J !== 8'h00)        begin bad++; $display("FAIL midreset_J: got %h want 00", J); end
    if (K !== 8'h00)        begin bad++; $display("FAIL midreset_K: got %h want 00", K); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
    if (err !== 1'b0)       begin bad++; $display("FAIL midreset_err: got %b want 0", err); end
    if (done !== 1'b0)      begin bad++; $display("FAIL midreset_done: got %b want 0", done); end
    reset = 1'b0;
    do_request(1'b0, 8'hA5, 1'b0, ew, lat, ph, fj, fk, lj, lk, eo, mo, qo);
    total = total + 3;
    if (lat != HOLD_T + 3) begin bad++; $display("FAIL midreset_latency: got %0d want %0d", lat, HOLD_T + 3); end
    if (eo !== 1'b0)      begin bad++; $display("FAIL midreset_after_err: got %b want 0", eo); end
    if (qo !== 8'hA5)     begin bad++; $display("FAIL midreset_q: got %h want A5", qo); end
  endtask

  task automatic test_back_to_back();
    int acc0, lat;
    load_q(8'h00);
    stuck = 1'b1;
    acc0 = acc_cnt;
    req_valid = 1'b1; mode = 1'b0; target = 8'hFF;
    lat = 0;
    while (lat < BUDGET) begin
      @(negedge clk);
      lat = lat + 1;
      if (done === 1'b1) break;
    end
    total = total + 4;
    if (err !== 1'b1)        begin bad++; $display("FAIL b2b_first_err: got %b want 1", err); end
    if (req_ready !== 1'b1)  begin bad++; $display("FAIL b2b_done_ready: got %b want 1", req_ready); end
    if (acc_cnt != acc0 + 1) begin bad++; $display("FAIL b2b_first_accepts: got %0d want %0d", acc_cnt - acc0, 1); end
    if (lat != (MAX_R + 1) * (HOLD_T + 2) + 1) begin
      bad++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, (MAX_R + 1) * (HOLD_T + 2) + 1);
    end
    target = 8'h33;
    @(posedge clk);
    @(negedge clk);
    total = total + 4;
    if (err !== 1'b0)        begin bad++; $display("FAIL b2b_err_cleared: got %b want 0", err); end
    if (done !== 1'b0)       begin bad++; $display("FAIL b2b_done_drop: got %b want 0", done); end
    if (req_ready !== 1'b0)  begin bad++; $display("FAIL b2b_busy_ready: got %b want 0", req_ready); end
    if (acc_cnt != acc0 + 2) begin bad++; $display("FAIL b2b_second_accept: got %0d want %0d", acc_cnt - acc0, 2); end
    req_valid = 1'b0;
    lat = 1;
    while (lat < BUDGET && done !== 1'b1) begin
      @(negedge clk);
      lat = lat + 1;
    end
    total = total + 3;
    if (lat != HOLD_T + 3) begin bad++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, HOLD_T + 3); end
    if (err !== 1'b0)      begin bad++; $display("FAIL b2b_second_err: got %b want 0", err); end
    if (Q_fb !== 8'h33)    begin bad++; $display("FAIL b2b_second_q: got %h want 33", Q_fb); end
    stuck = 1'b0;
  endtask

  task automatic test_random();
    logic [SIZE-1:0] ew, fj, fk, lj, lk, mo, qo, want_q, want_mis; int lat, ph, want_lat;
    logic eo, m, stk, fail;
    logic [SIZE-1:0] tgt;
    for (int i = 0; i < 1000; i++) begin
      m   = 1'($urandom_range(0, 1));
      tgt = 8'($urandom);
      stk = ($urandom_range(0, 3) == 0);
      do_request(m, tgt, stk, ew, lat, ph, fj, fk, lj, lk, eo, mo, qo);
      fail     = stk && ew[3];
      want_lat = fail ? (MAX_R + 1) * (HOLD_T + 2) + 1 : HOLD_T + 3;
      want_q   = fail ? (ew & 8'hF7) : ew;
      want_mis = fail ? 8'h08 : 8'h00;
      total = total + 4;
      if (lat != want_lat) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, want_lat); end
      if (eo !== fail)     begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", i, eo, fail); end
      if (mo !== want_mis) begin bad++; $display("FAIL rand_mismatch[%0d]: got %h want %h", i, mo, want_mis); end
      if (qo !== want_q)   begin bad++; $display("FAIL rand_q[%0d]: got %h want %h", i, qo, want_q); end
    end
    stuck = 1'b0;
  endtask

  task automatic test_monitor();
    total = total + 1;
    if (mon_bad != 0) begin bad++; $display("FAIL monitor: got %0d violations want 0", mon_bad); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_toggle();
    test_stuck();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_monitor();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
